// File: rtl/decode_pkg.sv
// Shared decode definitions for the decode/issue stage: field offsets, opcodes and
// per-opcode register-class rules.
package decode_pkg;

   localparam int XLEN_DEF = 32;
   localparam int VLEN_DEF = 256;

   localparam int OPC_LSB = 27;
   localparam int RD_LSB  = 22;
   localparam int RS1_LSB = 17;
   localparam int RS2_LSB = 12;
   localparam int ALU_LSB = 9;
   localparam int IMM_LSB = 1;

   typedef enum logic [4:0] {
      OP_NOP    = 5'd0,
      OP_ADD    = 5'd1,
      OP_ADDI   = 5'd2,
      OP_STORE  = 5'd3,
      OP_VALU   = 5'd4,
      OP_VSPLAT = 5'd5,
      OP_VRED   = 5'd6
   } opcode_e;

   function automatic logic writes_s(input logic [4:0] op);
      return op inside {OP_ADD, OP_ADDI, OP_VRED};
   endfunction

   function automatic logic writes_v(input logic [4:0] op);
      return op inside {OP_VALU, OP_VSPLAT};
   endfunction

   function automatic logic uses_rs1(input logic [4:0] op);
      return op inside {OP_ADD, OP_ADDI, OP_STORE, OP_VALU, OP_VSPLAT, OP_VRED};
   endfunction

   function automatic logic uses_rs2(input logic [4:0] op);
      return op inside {OP_ADD, OP_STORE, OP_VALU};
   endfunction

   // Both sources of an instruction live in the same class; VSPLAT reads a scalar.
   function automatic logic src_vec(input logic [4:0] op);
      return op inside {OP_VALU, OP_VRED};
   endfunction

   function automatic logic [31:0] reg_onehot(input logic en, input logic [4:0] idx);
      return en ? (32'd1 << idx) : 32'd0;
   endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// One busy bit per register of a single class; set on issue, cleared by writeback or
// by a flushed in-flight writer. A set wins over a clear of the same register.
module issue_scoreboard
   import decode_pkg::*;
#(
   parameter int NREG            = 32,
   parameter bit ZERO_NEVER_BUSY = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        set_en,
   input  logic [4:0]  set_addr,
   input  logic        clr_en,
   input  logic [4:0]  clr_addr,
   input  logic        flush_en,
   input  logic [4:0]  flush_addr,
   output logic [31:0] busy
);

   logic [NREG-1:0] busy_q, busy_d;
   logic [31:0]     set_vec, clr_vec;

   // NOTE: every always_comb output gets a default before any conditional update,
   // otherwise synthesis infers a latch.
   always_comb begin
      set_vec = reg_onehot(set_en, set_addr);
      if (ZERO_NEVER_BUSY) set_vec[0] = 1'b0;
      clr_vec = reg_onehot(clr_en, clr_addr) | reg_onehot(flush_en, flush_addr);
      busy_d  = (busy_q & ~clr_vec[NREG-1:0]) | set_vec[NREG-1:0];
      busy    = '0;
      busy[NREG-1:0] = busy_q;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) busy_q <= '0;
      else      busy_q <= busy_d;
   end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: decodes, checks scalar/vector hazards and registers one entry for EX.
// Optional feature: define DECODE_WB_BYPASS_EN to forward same-cycle writeback data.
module decode_issue_stage
   import decode_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int VLEN  = VLEN_DEF,
   parameter int NSREG = 32,
   parameter int NVREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   output logic [4:0]      rf_sra1,
   output logic [4:0]      rf_sra2,
   input  logic [XLEN-1:0] rf_srd1,
   input  logic [XLEN-1:0] rf_srd2,
   output logic [4:0]      rf_vra1,
   output logic [4:0]      rf_vra2,
   input  logic [VLEN-1:0] rf_vrd1,
   input  logic [VLEN-1:0] rf_vrd2,
   input  logic            wb_swe,
   input  logic            wb_vwe,
   input  logic [4:0]      wb_rd,
   input  logic [VLEN-1:0] wb_data,
   input  logic            flush,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [4:0]      ex_opcode,
   output logic [2:0]      ex_aluop,
   output logic [4:0]      ex_rd,
   output logic            ex_wr_s,
   output logic            ex_wr_v,
   output logic [XLEN-1:0] ex_rs1,
   output logic [XLEN-1:0] ex_rs2,
   output logic [VLEN-1:0] ex_vrs1,
   output logic [VLEN-1:0] ex_vrs2,
   output logic [XLEN-1:0] ex_imm,
   output logic [15:0]     stall_cnt
);

   logic [4:0]      opcode, rd, rs1, rs2;
   logic [2:0]      aluop;
   logic [XLEN-1:0] imm_ext;
   logic [31:0]     s_busy, v_busy, s_haz_busy, v_haz_busy;
   logic            byp_s1, byp_s2, byp_v1, byp_v2;
   logic            rs1_busy, rs2_busy, rd_busy, hazard, accept;
   logic            unused_instr_bit;

   assign opcode  = in_instr[OPC_LSB +: 5];
   assign rd      = in_instr[RD_LSB  +: 5];
   assign rs1     = in_instr[RS1_LSB +: 5];
   assign rs2     = in_instr[RS2_LSB +: 5];
   assign aluop   = in_instr[ALU_LSB +: 3];
   assign imm_ext = XLEN'($signed(in_instr[IMM_LSB +: 16]));
   assign unused_instr_bit = in_instr[0];

   assign rf_sra1 = rs1;
   assign rf_sra2 = rs2;
   assign rf_vra1 = rs1;
   assign rf_vra2 = rs2;

`ifdef DECODE_WB_BYPASS_EN
   // A register retiring this cycle is treated as free and its value taken from wb_data.
   assign s_haz_busy = s_busy & ~reg_onehot(wb_swe, wb_rd);
   assign v_haz_busy = v_busy & ~reg_onehot(wb_vwe, wb_rd);
   assign byp_s1 = wb_swe && (wb_rd == rs1) && (rs1 != 5'd0);
   assign byp_s2 = wb_swe && (wb_rd == rs2) && (rs2 != 5'd0);
   assign byp_v1 = wb_vwe && (wb_rd == rs1);
   assign byp_v2 = wb_vwe && (wb_rd == rs2);
`else
   assign s_haz_busy = s_busy;
   assign v_haz_busy = v_busy;
   assign byp_s1 = 1'b0;
   assign byp_s2 = 1'b0;
   assign byp_v1 = 1'b0;
   assign byp_v2 = 1'b0;
`endif

   assign rs1_busy = src_vec(opcode) ? v_haz_busy[rs1] : s_haz_busy[rs1];
   assign rs2_busy = src_vec(opcode) ? v_haz_busy[rs2] : s_haz_busy[rs2];
   assign rd_busy  = (writes_s(opcode) && s_haz_busy[rd]) || (writes_v(opcode) && v_haz_busy[rd]);
   assign hazard   = (uses_rs1(opcode) && rs1_busy) || (uses_rs2(opcode) && rs2_busy) || rd_busy;

   // Gating with rst keeps the stage closed while reset is held.
   assign in_ready = rst && (!ex_valid || ex_ready) && !hazard && !flush;
   assign accept   = in_valid && in_ready;

   issue_scoreboard #(.NREG(NSREG), .ZERO_NEVER_BUSY(1'b1)) u_sb_scalar (
      .clk        (clk),
      .rst        (rst),
      .set_en     (accept && writes_s(opcode)),
      .set_addr   (rd),
      .clr_en     (wb_swe),
      .clr_addr   (wb_rd),
      .flush_en   (flush && ex_valid && ex_wr_s),
      .flush_addr (ex_rd),
      .busy       (s_busy)
   );

   issue_scoreboard #(.NREG(NVREG), .ZERO_NEVER_BUSY(1'b0)) u_sb_vector (
      .clk        (clk),
      .rst        (rst),
      .set_en     (accept && writes_v(opcode)),
      .set_addr   (rd),
      .clr_en     (wb_vwe),
      .clr_addr   (wb_rd),
      .flush_en   (flush && ex_valid && ex_wr_v),
      .flush_addr (ex_rd),
      .busy       (v_busy)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid  <= 1'b0;
         ex_opcode <= '0;
         ex_aluop  <= '0;
         ex_rd     <= '0;
         ex_wr_s   <= 1'b0;
         ex_wr_v   <= 1'b0;
         ex_rs1    <= '0;
         ex_rs2    <= '0;
         ex_vrs1   <= '0;
         ex_vrs2   <= '0;
         ex_imm    <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (accept) begin
         ex_valid  <= 1'b1;
         ex_opcode <= opcode;
         ex_aluop  <= aluop;
         ex_rd     <= rd;
         ex_wr_s   <= writes_s(opcode);
         ex_wr_v   <= writes_v(opcode);
         ex_rs1    <= byp_s1 ? wb_data[XLEN-1:0] : rf_srd1;
         ex_rs2    <= byp_s2 ? wb_data[XLEN-1:0] : rf_srd2;
         ex_vrs1   <= byp_v1 ? wb_data : rf_vrd1;
         ex_vrs2   <= byp_v2 ? wb_data : rf_vrd2;
         ex_imm    <= imm_ext;
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cnt <= '0;
      else if (in_valid && !in_ready && !flush && stall_cnt != 16'hFFFF)
         stall_cnt <= stall_cnt + 16'd1;
   end

endmodule

// File: doc/decode_issue_stage.md
DECODE_ISSUE_STAGE -- requirements
Module: decode_issue_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, scalar datapath width.
REQ-002 SHALL have parameter VLEN, default 256, vector register width; a multiple of XLEN.
REQ-003 SHALL have parameter NSREG, default 32, scalar register count (at most 32).
REQ-004 SHALL have parameter NVREG, default 32, vector register count (at most 32).
REQ-005 SHALL have ports: clk in 1, rising-edge clock; rst in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: in_valid in 1, instruction offered; in_ready out 1, instruction accepted; in_instr in 32, instruction word.
REQ-007 SHALL have ports: rf_sra1/rf_sra2 out 5, scalar read addresses; rf_srd1/rf_srd2 in XLEN, combinational scalar read data.
REQ-008 SHALL have ports: rf_vra1/rf_vra2 out 5, vector read addresses; rf_vrd1/rf_vrd2 in VLEN, combinational vector read data.
REQ-009 SHALL have ports: wb_swe in 1, scalar write; wb_vwe in 1, vector write; wb_rd in 5, destination; wb_data in VLEN, write data (scalar uses [XLEN-1:0]).
REQ-010 SHALL have port: flush in 1, discard the held entry.
REQ-011 SHALL have ports: ex_valid out 1; ex_ready in 1; ex_opcode out 5; ex_aluop out 3; ex_rd out 5; ex_wr_s out 1; ex_wr_v out 1.
REQ-012 SHALL have ports: ex_rs1/ex_rs2 out XLEN, scalar operands; ex_vrs1/ex_vrs2 out VLEN, vector operands; ex_imm out XLEN, sign-extended in_instr[16:1].
REQ-013 SHALL have port: stall_cnt out 16, hazard-stall cycle counter.

Function
REQ-014 SHALL decode fields: opcode [31:27], rd [26:22], rs1 [21:17], rs2 [16:12], aluop [11:9], imm [16:1].
REQ-015 SHALL classify each opcode with decode_pkg functions: writes_s, writes_v, uses_rs1, uses_rs2, src_vec.
REQ-016 SHALL drive rf_sra1/rf_vra1 = rs1 and rf_sra2/rf_vra2 = rs2 combinationally from in_instr.
REQ-017 SHALL keep one busy bit per scalar and per vector register in the scoreboard; scalar register 0 is never busy.
REQ-018 SHALL flag a hazard when any used source is busy in its class, or the rd of a writing instruction is busy (WAW).
REQ-019 SHALL drive in_ready = (!ex_valid || ex_ready) && !hazard && !flush.
REQ-020 SHALL, on accept (in_valid && in_ready), load the output register next edge, set ex_valid, and capture operands from rf_*rd.
REQ-021 SHALL set the busy bit of rd on accept when writes_s or writes_v.
REQ-022 SHALL clear the busy bit of wb_rd in the matching class on wb_swe or wb_vwe.
REQ-023 SHALL let set win over clear when both hit the same register in the same cycle.
REQ-024 SHALL clear ex_valid on ex_ready with no accept; ex outputs SHALL hold stable while ex_valid && !ex_ready.
REQ-025 SHALL, on flush: perform no EX transfer; clear ex_valid next edge; clear the busy bit of the held entry's rd if it was a writer.
REQ-026 SHALL increment stall_cnt on each cycle with in_valid && !in_ready && !flush, saturating at 16'hFFFF.

Reset
REQ-027 SHALL, on rst low, clear ex_valid, all busy bits, stall_cnt and all ex_* data outputs to 0, immediately and asynchronously.
REQ-028 SHALL drop in_ready to 0 during reset, and accept no instruction before the first edge after release.

Configuration
REQ-029 SHALL, with DECODE_WB_BYPASS_EN defined, ignore in hazard evaluation a busy bit being cleared by writeback in the same cycle, and capture wb_data instead of rf data for that source.
REQ-030 SHALL, without DECODE_WB_BYPASS_EN, compute hazards from registered busy bits only, so writeback adds one stall cycle.

Structure
REQ-031 SHALL place opcode constants, field offsets, classification functions and the default XLEN/VLEN in package decode_pkg.
REQ-032 SHALL implement the busy bits as sub-module issue_scoreboard, parametrised by register count and instantiated once per class.

Verification
REQ-033 SHALL cover: ALU op r3 <- r1,r2 with r1/r2 idle and ex_ready=1 -> ex_valid next cycle, ex_rs1=rf value, sr3 busy.
REQ-034 SHALL cover: back-to-back r3 <- .. then r4 <- r3 -> second stalls, in_ready=0, stall_cnt counts until wb_swe on r3.
REQ-035 SHALL cover: wb_swe r3 with data 0xDEADBEEF in the stall cycle -> with bypass, accept that cycle and ex_rs1=0xDEADBEEF; without bypass, accept next cycle.
REQ-036 SHALL cover: vector write v5 then flush with ex_ready=0 -> ex_valid=0 next cycle, v5 busy cleared, no EX transfer.
REQ-037 SHALL cover: in_valid held high with r1 busy for 70000 cycles -> stall_cnt saturates at 0xFFFF.
REQ-038 SHALL cover: rst asserted mid-stall with entries busy -> all outputs 0 and scoreboard empty immediately.
